soc_tcdm_slave_arbiter: RTL

Shares one contiguous TCDM slave (private L2 bank or boot ROM port) between NR_MASTERS TCDM requesters inside the SoC interconnect. Arbitration is round-robin with a starvation override. Each grant is tracked through a fixed-latency response pipeline, so r_valid goes only to the owning master. The block sits between the contiguous-crossbar master side and a single bank.

---
 rtl/soc_tcdm_slave_arbiter_pkg.sv | 16 +
 rtl/soc_tcdm_resp_tracker.sv | 65 ++++++
 rtl/soc_tcdm_slave_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/soc_tcdm_slave_arbiter_pkg.sv
// Shared constants and helpers for the SoC TCDM interconnect slave arbiter.
package pkg_soc_interconnect;

  // Default number of consecutive lost cycles before a master is forced to the front
  localparam int unsigned SOC_TCDM_ARB_STARVE_LIMIT = 8;

  // Cyclic index addition for base and off both below n
  function automatic int unsigned soc_tcdm_arb_wrap(input int unsigned base,
                                                    input int unsigned off,
                                                    input int unsigned n);
    int unsigned s;
    s = base + off;
    return (s >= n) ? (s - n) : s;
  endfunction

endpackage

// File: rtl/soc_tcdm_resp_tracker.sv
// Fixed-latency response tracker: remembers which master owns each accepted
// request and routes the slave response back to that master only.
module soc_tcdm_resp_tracker
  import pkg_soc_interconnect::*;
#(
  parameter int unsigned NR_MASTERS   = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned RESP_LATENCY = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          push_i,
  input  logic [$clog2(NR_MASTERS)-1:0] push_idx_i,
  input  logic                          s_r_valid_i,
  input  logic [DATA_WIDTH-1:0]         s_r_rdata_i,
  output logic [NR_MASTERS-1:0]         m_r_valid_o,
  output logic [DATA_WIDTH-1:0]         m_r_rdata_o,
  output logic                          resp_err_o
);

  localparam int unsigned IDX_W = $clog2(NR_MASTERS);

  typedef struct packed {
    logic             valid;
    logic [IDX_W-1:0] idx;
  } soc_tcdm_arb_resp_entry_t;

  soc_tcdm_arb_resp_entry_t pipe_q [RESP_LATENCY];
  soc_tcdm_arb_resp_entry_t pipe_d [RESP_LATENCY];
  soc_tcdm_arb_resp_entry_t tail;

  assign tail = pipe_q[RESP_LATENCY-1];

  // Next pipeline contents: new grant enters stage 0, everything else moves one stage on
  always_comb begin
    pipe_d[0].valid = push_i;
    pipe_d[0].idx   = push_i ? push_idx_i : '0;
    for (int i = 1; i < RESP_LATENCY; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
  end

  // Pipeline register; reset discards anything still in flight
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < RESP_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      pipe_q <= pipe_d;
    end
  end

  // Route a response to the owner of the tail entry; an untracked response is flagged
  always_comb begin
    m_r_valid_o = '0;
    m_r_rdata_o = '0;
    resp_err_o  = s_r_valid_i & ~tail.valid;
    if (tail.valid && s_r_valid_i) begin
      m_r_valid_o[tail.idx] = 1'b1;
      m_r_rdata_o           = s_r_rdata_i;
    end
  end

endmodule

// File: rtl/soc_tcdm_slave_arbiter.sv
// Round-robin TCDM slave arbiter with starvation override; shares one bank
// between NR_MASTERS requesters with zero added request latency.
module soc_tcdm_slave_arbiter
  import pkg_soc_interconnect::*;
#(
  parameter int unsigned NR_MASTERS   = 4,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned RESP_LATENCY = 1,
  parameter int unsigned STARVE_LIMIT = SOC_TCDM_ARB_STARVE_LIMIT
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NR_MASTERS-1:0]                m_req_i,
  input  logic [NR_MASTERS*ADDR_WIDTH-1:0]     m_add_i,
  input  logic [NR_MASTERS-1:0]                m_wen_i,
  input  logic [NR_MASTERS*DATA_WIDTH-1:0]     m_wdata_i,
  input  logic [NR_MASTERS*DATA_WIDTH/8-1:0]   m_be_i,
  output logic [NR_MASTERS-1:0]                m_gnt_o,
  output logic [NR_MASTERS-1:0]                m_r_valid_o,
  output logic [DATA_WIDTH-1:0]                m_r_rdata_o,
  output logic                                 s_req_o,
  output logic [ADDR_WIDTH-1:0]                s_add_o,
  output logic                                 s_wen_o,
  output logic [DATA_WIDTH-1:0]                s_wdata_o,
  output logic [DATA_WIDTH/8-1:0]              s_be_o,
  input  logic                                 s_gnt_i,
  input  logic                                 s_r_valid_i,
  input  logic [DATA_WIDTH-1:0]                s_r_rdata_i,
  output logic                                 resp_err_o
);

  localparam int unsigned IDX_W = $clog2(NR_MASTERS);
  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam int unsigned BE_W  = DATA_WIDTH / 8;

  logic [IDX_W-1:0]      rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]      wait_cnt_q [NR_MASTERS];
  logic [CNT_W-1:0]      wait_cnt_d [NR_MASTERS];
  logic [NR_MASTERS-1:0] starved;
  logic [IDX_W-1:0]      sel;
  logic                  sel_starved;
  logic                  any_req;
  logic                  handshake;

  assign any_req   = |m_req_i;
  assign handshake = any_req & s_gnt_i;

  for (genvar gi = 0; gi < NR_MASTERS; gi++) begin : g_starve
    assign starved[gi] = m_req_i[gi] && (wait_cnt_q[gi] == CNT_W'(STARVE_LIMIT));
  end

  // Pick the lowest starving requester, otherwise the first requester at/after rr_ptr
  always_comb begin
    sel         = '0;
    sel_starved = 1'b0;
    for (int i = NR_MASTERS - 1; i >= 0; i--) begin
      if (starved[i]) begin
        sel         = IDX_W'(i);
        sel_starved = 1'b1;
      end
    end
    if (!sel_starved) begin
      for (int k = NR_MASTERS - 1; k >= 0; k--) begin
        if (m_req_i[IDX_W'(soc_tcdm_arb_wrap(32'(rr_ptr_q), 32'(k), NR_MASTERS))]) begin
          sel = IDX_W'(soc_tcdm_arb_wrap(32'(rr_ptr_q), 32'(k), NR_MASTERS));
        end
      end
    end
  end

  // Forward the selected master's request fields and return the slave grant to it
  always_comb begin
    s_req_o   = any_req;
    s_add_o   = '0;
    s_wen_o   = 1'b0;
    s_wdata_o = '0;
    s_be_o    = '0;
    m_gnt_o   = '0;
    if (any_req) begin
      s_add_o      = m_add_i[sel*ADDR_WIDTH +: ADDR_WIDTH];
      s_wen_o      = m_wen_i[sel];
      s_wdata_o    = m_wdata_i[sel*DATA_WIDTH +: DATA_WIDTH];
      s_be_o       = m_be_i[sel*BE_W +: BE_W];
      m_gnt_o[sel] = s_gnt_i;
    end
  end

  // Next pointer and per-master wait counters (saturating; cleared when idle or served)
  always_comb begin
    rr_ptr_d = handshake ? IDX_W'(soc_tcdm_arb_wrap(32'(sel), 1, NR_MASTERS)) : rr_ptr_q;
    for (int i = 0; i < NR_MASTERS; i++) begin
      wait_cnt_d[i] = wait_cnt_q[i];
      if (!m_req_i[i]) begin
        wait_cnt_d[i] = '0;
      end else if (handshake && (sel == IDX_W'(i))) begin
        wait_cnt_d[i] = '0;
      end else if (wait_cnt_q[i] != CNT_W'(STARVE_LIMIT)) begin
        wait_cnt_d[i] = wait_cnt_q[i] + 1'b1;
      end
    end
  end

  // Arbitration state registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_ptr_q <= '0;
      for (int i = 0; i < NR_MASTERS; i++) begin
        wait_cnt_q[i] <= '0;
      end
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  soc_tcdm_resp_tracker #(
    .NR_MASTERS   (NR_MASTERS),
    .DATA_WIDTH   (DATA_WIDTH),
    .RESP_LATENCY (RESP_LATENCY)
  ) u_resp_tracker (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (handshake),
    .push_idx_i  (sel),
    .s_r_valid_i (s_r_valid_i),
    .s_r_rdata_i (s_r_rdata_i),
    .m_r_valid_o (m_r_valid_o),
    .m_r_rdata_o (m_r_rdata_o),
    .resp_err_o  (resp_err_o)
  );

endmodule
